// File: rtl/hack_cpu_if.sv
// Bus between the Hack core and its instruction ROM / data RAM / halt control.
// The core takes the master side; memories and the debug controller take the slave side.
interface hack_cpu_if;
  logic        halt;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;
  logic        fetch;

  modport master (
    input  halt, instruction, inM,
    output outM, writeM, addressM, pc, fetch
  );

  modport slave (
    output halt, instruction, inM,
    input  outM, writeM, addressM, pc, fetch
  );
endinterface

// File: rtl/hack_cpu.sv
// Two-phase Hack CPU core: FETCH waits out the synchronous ROM/RAM read,
// EXEC decodes, drives the ALU and commits A/D/PC at the edge ending EXEC.

// Hack ALU: optional zero/negate on each input, add or AND, optional negate.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] xs;
  logic [15:0] ys;
  logic [15:0] res;

  // Precondition both operands, combine them, then postcondition the result.
  always_comb begin
    // NOTE: every variable is given a value before any condition touches it,
    // so no path leaves it unassigned and no latch is inferred.
    xs  = zx ? 16'h0000 : x;
    ys  = zy ? 16'h0000 : y;
    if (nx) xs = ~xs;
    if (ny) ys = ~ys;
    res = f ? (xs + ys) : (xs & ys);
    if (no) res = ~res;
  end

  assign out = res;
  assign zr  = (res == 16'h0000);
  assign ng  = res[15];
endmodule

module hack_cpu (
  input  logic             clk,
  input  logic             rst_n,
  hack_cpu_if.master       bus
);
  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;
  logic        write_m;

  // Instruction fields; only meaningful for C-instructions (bit 15 set).
  logic        is_c;
  logic        sel_m;
  logic        dst_a, dst_d, dst_m;
  logic        j_lt, j_eq, j_gt;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic        jump;

  assign is_c  = bus.instruction[15];
  assign sel_m = bus.instruction[12];
  assign dst_a = bus.instruction[5];
  assign dst_d = bus.instruction[4];
  assign dst_m = bus.instruction[3];
  assign j_lt  = bus.instruction[2];
  assign j_eq  = bus.instruction[1];
  assign j_gt  = bus.instruction[0];

  // Operands always come from the pre-commit registers, so an instruction
  // that writes A or D still reads the old values.
  assign alu_y = sel_m ? bus.inM : a_q;

  alu u_alu (
    .x   (d_q),
    .y   (alu_y),
    .zx  (bus.instruction[11]),
    .nx  (bus.instruction[10]),
    .zy  (bus.instruction[9]),
    .ny  (bus.instruction[8]),
    .f   (bus.instruction[7]),
    .no  (bus.instruction[6]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump = (j_lt & alu_ng) | (j_eq & alu_zr) | (j_gt & ~alu_zr & ~alu_ng);

  // FSM state register; reset lands in FETCH so writeM drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Architectural registers; commits happen only when the FSM leaves EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= 15'h0000;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  // Next-state, register commit values and the RAM write strobe.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    pc_d    = pc_q;
    write_m = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!bus.halt) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 15'd1;
        if (!is_c) begin
          a_d = {1'b0, bus.instruction[14:0]};
        end else begin
          if (dst_a) a_d = alu_out;
          if (dst_d) d_d = alu_out;
          write_m = dst_m;
          if (jump) pc_d = a_q[14:0];
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.addressM = a_q[14:0];
  assign bus.fetch    = (state_q == S_FETCH);
  assign bus.writeM   = write_m;
  assign bus.outM     = write_m ? alu_out : 16'h0000;
endmodule

// File: tb/tb_hack_cpu.sv
// Bench for hack_cpu: ROM/RAM models around the core, a scoreboard of
// expected EXEC cycles checked by a monitor, and one task per scenario.
module tb_hack_cpu;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hack_cpu_if bus ();

  hack_cpu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] pc;
    logic        wr;
    logic        chk_addr;
    logic [14:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [15:0] rom [32768];
  logic [14:0] ram_addr;
  logic [15:0] ram_data;
  int          checks = 0;
  int          errors = 0;
  int          edges;
  int          wr_cyc = 0;
  logic        mon_en = 1'b0;

  // Synchronous ROM and single-word RAM: data one cycle after the address.
  always @(posedge clk) begin
    bus.instruction <= rom[bus.pc];
    bus.inM         <= (bus.addressM == ram_addr) ? ram_data : 16'h0000;
  end

  // Rising edges since reset release; cycle number seen at a negedge is edges+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Monitor: FETCH must be quiet, each EXEC must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.writeM === 1'b1 && wr_cyc == 0) wr_cyc = edges + 1;
      if (bus.fetch) begin
        checks++;
        if (bus.writeM !== 1'b0 || bus.outM !== 16'h0000) begin
          errors++;
          $display("FAIL fetch_quiet: writeM=%b outM=%h, required 0/0000", bus.writeM, bus.outM);
        end
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exec: pc=%h executed, required no more EXEC", bus.pc);
      end else begin
        e = q.pop_front();
        checks++;
        if (bus.pc !== e.pc) begin
          errors++;
          $display("FAIL exec_pc: pc=%h, required %h", bus.pc, e.pc);
        end
        checks++;
        if (bus.writeM !== e.wr) begin
          errors++;
          $display("FAIL exec_writeM at pc %h: writeM=%b, required %b", e.pc, bus.writeM, e.wr);
        end
        checks++;
        if (bus.outM !== (e.wr ? e.data : 16'h0000)) begin
          errors++;
          $display("FAIL exec_outM at pc %h: outM=%h, required %h", e.pc, bus.outM,
                   e.wr ? e.data : 16'h0000);
        end
        if (e.wr || e.chk_addr) begin
          checks++;
          if (bus.addressM !== e.addr) begin
            errors++;
            $display("FAIL exec_addressM at pc %h: addressM=%h, required %h", e.pc, bus.addressM, e.addr);
          end
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
    ram_addr = 15'h0000;
    ram_data = 16'h0000;
    q.delete();
  endtask

  task automatic push_exp(input logic [14:0] p, input logic w, input logic ca,
                          input logic [14:0] a, input logic [15:0] d);
    q.push_back('{p, w, ca, a, d});
  endtask

  // Pulse reset across two edges, release on a falling edge, arm the monitor.
  task automatic start_program();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    wr_cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d EXEC cycles outstanding after %0d cycles, required 0", name, q.size(), n);
      q.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    bit found = 0;
    #1;
    checks++;
    if ({bus.pc, bus.addressM, bus.writeM, bus.outM, bus.fetch} !==
        {15'h0, 15'h0, 1'b0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: pc=%h addressM=%h writeM=%b outM=%h fetch=%b, required 0/0/0/0/1",
               bus.pc, bus.addressM, bus.writeM, bus.outM, bus.fetch);
    end
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE308;
    start_program();
    mon_en = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (!bus.fetch && bus.pc == 15'd3) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_reach_store: store EXEC at pc 3 not seen, required within 30 cycles");
    end else begin
      checks++;
      if ({bus.writeM, bus.outM, bus.addressM} !== {1'b1, 16'd5, 15'd100}) begin
        errors++;
        $display("FAIL reset_pre_store: writeM=%b outM=%h addressM=%h, required 1/0005/0064",
                 bus.writeM, bus.outM, bus.addressM);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.writeM, bus.outM, bus.fetch, bus.pc, bus.addressM} !==
        {1'b0, 16'h0, 1'b1, 15'h0, 15'h0}) begin
      errors++;
      $display("FAIL reset_mid_exec: writeM=%b outM=%h fetch=%b pc=%h addressM=%h, required 0/0/1/0/0",
               bus.writeM, bus.outM, bus.fetch, bus.pc, bus.addressM);
    end
    // M=D at address 0 exposes A=0 (address) and D=0 (data) after release.
    clear_mem();
    rom[0] = 16'hE308;
    push_exp(15'd0, 1'b1, 1'b1, 15'd0, 16'd0);
    start_program();
    wait_drain("reset", 20);
  endtask

  task automatic test_arith_store();
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003;
    rom[3] = 16'hE090; rom[4] = 16'h0064; rom[5] = 16'hE308;
    for (int i = 0; i < 5; i++) push_exp(15'(i), 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd5, 1'b1, 1'b1, 15'd100, 16'd8);
    start_program();
    wait_drain("arith", 40);
    checks++;
    if (wr_cyc != 12) begin
      errors++;
      $display("FAIL arith_write_cycle: first writeM in cycle %0d, required 12", wr_cyc);
    end
    @(negedge clk);
    checks++;
    if (bus.pc !== 15'd6) begin
      errors++;
      $display("FAIL arith_pc: pc=%h, required 0006", bus.pc);
    end
  endtask

  task automatic test_mem_operand();
    bit found = 0;
    clear_mem();
    ram_addr = 15'd200;
    ram_data = 16'h0010;
    rom[0] = 16'h00C8; rom[1] = 16'hFC10; rom[2] = 16'hE390; rom[3] = 16'hE308;
    push_exp(15'd0, 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd1, 1'b0, 1'b1, 15'd200, 16'd0);
    push_exp(15'd2, 1'b0, 1'b1, 15'd200, 16'd0);
    push_exp(15'd3, 1'b1, 1'b1, 15'd200, 16'h000F);
    start_program();
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.fetch && bus.pc == 15'd1) found = 1;
    end
    checks++;
    if (!found || bus.addressM !== 15'd200) begin
      errors++;
      $display("FAIL mem_fetch_addr: found=%0d addressM=%h, required 1/00c8", found, bus.addressM);
    end
    wait_drain("mem", 30);
  endtask

  task automatic test_jumps();
    clear_mem();
    rom[0] = 16'h0007; rom[1] = 16'hEE90; rom[2] = 16'hE301; rom[3] = 16'h0007;
    rom[4] = 16'hE304; rom[7] = 16'hEA90; rom[8] = 16'h0009; rom[9] = 16'hE302;
    push_exp(15'd0, 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd1, 1'b0, 1'b1, 15'd7, 16'd0);
    push_exp(15'd2, 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd3, 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd4, 1'b0, 1'b1, 15'd7, 16'd0);
    push_exp(15'd7, 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd8, 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd9, 1'b0, 1'b1, 15'd9, 16'd0);
    start_program();
    wait_drain("jumps", 40);
    @(negedge clk);
    checks++;
    if (bus.pc !== 15'd9) begin
      errors++;
      $display("FAIL jeq_target: pc=%h, required 0009", bus.pc);
    end
  endtask

  task automatic test_old_value();
    clear_mem();
    rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'h000A; rom[3] = 16'hE0A8;
    rom[4] = 16'hE308; rom[5] = 16'h0014; rom[6] = 16'hEDF7; rom[20] = 16'hE308;
    for (int i = 0; i < 3; i++) push_exp(15'(i), 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd3, 1'b1, 1'b1, 15'd10, 16'd13);
    push_exp(15'd4, 1'b1, 1'b1, 15'd13, 16'd3);
    push_exp(15'd5, 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'd6, 1'b0, 1'b1, 15'd20, 16'd0);
    push_exp(15'd20, 1'b1, 1'b1, 15'd21, 16'd21);
    start_program();
    wait_drain("old_value", 40);
    @(negedge clk);
    checks++;
    if (bus.pc !== 15'd21) begin
      errors++;
      $display("FAIL old_value_pc: pc=%h, required 0015", bus.pc);
    end
  endtask

  task automatic test_wrap_halt();
    clear_mem();
    rom[0] = 16'h1234; rom[1] = 16'hEC10; rom[2] = 16'h7FFF; rom[3] = 16'hEA87;
    rom[32767] = 16'hE308;
    for (int i = 0; i < 4; i++) push_exp(15'(i), 1'b0, 1'b0, 15'd0, 16'd0);
    push_exp(15'h7FFF, 1'b1, 1'b1, 15'h7FFF, 16'h1234);
    start_program();
    wait_drain("wrap", 30);
    @(negedge clk);
    checks++;
    if (bus.pc !== 15'h0000) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h, required 0000", bus.pc);
    end
    // Hold three extra FETCH cycles; swap in M=D to expose A and D afterwards.
    bus.halt = 1'b1;
    rom[0]   = 16'hE308;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.fetch, bus.pc, bus.addressM, bus.writeM} !== {1'b1, 15'h0, 15'h7FFF, 1'b0}) begin
        errors++;
        $display("FAIL halt_hold %0d: fetch=%b pc=%h addressM=%h writeM=%b, required 1/0000/7fff/0",
                 i, bus.fetch, bus.pc, bus.addressM, bus.writeM);
      end
    end
    bus.halt = 1'b0;
    push_exp(15'd0, 1'b1, 1'b1, 15'h7FFF, 16'h1234);
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fetch !== 1'b0) begin
      errors++;
      $display("FAIL halt_resume: fetch=%b one cycle after halt fell, required 0", bus.fetch);
    end
    wait_drain("halt", 10);
  endtask

  initial begin
    bus.halt = 1'b0;
    test_reset();
    test_arith_store();
    test_mem_operand();
    test_jumps();
    test_old_value();
    test_wrap_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
